// File: rtl/alu_add_hold_pkg.sv
// Shared constants and stage-1 record for the ALU adder hold path.
package alu_add_hold_pkg;

    localparam int W = 8;
    localparam logic [W-1:0] RST_VAL = 8'h00;

    localparam logic [2:0] OP_SUMS = 3'd0;
    localparam logic [2:0] OP_ANDS = 3'd1;
    localparam logic [2:0] OP_EORS = 3'd2;
    localparam logic [2:0] OP_ORS  = 3'd3;
    localparam logic [2:0] OP_SRS  = 3'd4;

    // Stage-1 register contents; daa/dsa are already qualified by SUMS.
    typedef struct packed {
        logic         valid;
        logic [W-1:0] raw;
        logic         acr_raw;
        logic         avr;
        logic         hc;
        logic         daa;
        logic         dsa;
    } s1_t;

endpackage

// File: rtl/alu_dec_adjust.sv
// Stage-2 NMOS-6502 decimal correction of the binary stage-1 result.
module alu_dec_adjust
    import alu_add_hold_pkg::*;
(
    input  logic [W-1:0] raw,
    input  logic         acr_raw,
    input  logic         hc,
    input  logic         daa,
    input  logic         dsa,
    output logic [W-1:0] result,
    output logic         acr
);

    logic lo_fix;
    logic hi_fix;

    always_comb begin
        lo_fix = hc | (raw[3:0] > 4'd9);
        hi_fix = acr_raw | (raw > 8'h99);
        result = raw;
        acr    = acr_raw;
        if (daa) begin
            // Both tests look at the raw sum, not the partially fixed value.
            result = raw + (lo_fix ? 8'h06 : 8'h00) + (hi_fix ? 8'h60 : 8'h00);
            acr    = hi_fix;
        end else if (dsa) begin
            // Nibble-local: no borrow crosses from low to high nibble.
            result[3:0] = hc      ? raw[3:0] : raw[3:0] - 4'd6;
            result[7:4] = acr_raw ? raw[7:4] : raw[7:4] - 4'd6;
        end
    end

endmodule

// File: rtl/alu_add_hold.sv
// Two-stage ALU result path: binary op + flags, then decimal correction into ADD.
module alu_add_hold
    import alu_add_hold_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         GO,
    input  logic [W-1:0] AI,
    input  logic [W-1:0] BI,
    input  logic         CI,
    input  logic [2:0]   OP,
    input  logic         DAA,
    input  logic         DSA,
    input  logic         ADD_SB_EN,
    input  logic         ADD_ADL_EN,
    output logic [W-1:0] SB_OUT,
    output logic [W-1:0] ADL_OUT,
    output logic [W-1:0] ADD,
    output logic         ACR,
    output logic         AVR,
    output logic         HC,
    output logic         VALID,
    output logic         BUSY
);

    s1_t          s1_d;
    s1_t          s1_q;
    logic [W:0]   sum9;
    logic [W-1:0] adj_result;
    logic         adj_acr;

    always_comb begin
        sum9       = {1'b0, AI} + {1'b0, BI} + {{W{1'b0}}, CI};
        s1_d       = '0;
        s1_d.valid = 1'b1;
        case (OP)
            OP_SUMS: begin
                s1_d.raw     = sum9[W-1:0];
                s1_d.acr_raw = sum9[W];
                // Carry into bit 4 is the carry out of the low nibble.
                s1_d.hc      = AI[4] ^ BI[4] ^ sum9[4];
                s1_d.avr     = ~(AI[W-1] ^ BI[W-1]) & (AI[W-1] ^ sum9[W-1]);
                s1_d.daa     = DAA;
                s1_d.dsa     = DSA;
            end
            OP_ANDS: s1_d.raw = AI & BI;
            OP_EORS: s1_d.raw = AI ^ BI;
            OP_SRS: begin
                s1_d.raw     = {CI, AI[W-1:1]};
                s1_d.acr_raw = AI[0];
            end
            default: s1_d.raw = AI | BI;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q <= '0;
        end else if (GO) begin
            s1_q <= s1_d;
        end else begin
            s1_q.valid <= 1'b0;
        end
    end

    alu_dec_adjust u_dec_adjust (
        .raw     (s1_q.raw),
        .acr_raw (s1_q.acr_raw),
        .hc      (s1_q.hc),
        .daa     (s1_q.daa),
        .dsa     (s1_q.dsa),
        .result  (adj_result),
        .acr     (adj_acr)
    );

    // VALID is a one-cycle strobe qualifying fresh ADD/flags; there is no
    // ready/backpressure, so every GO completes exactly two cycles later.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ADD   <= RST_VAL;
            ACR   <= 1'b0;
            AVR   <= 1'b0;
            HC    <= 1'b0;
            VALID <= 1'b0;
        end else begin
            VALID <= s1_q.valid;
            if (s1_q.valid) begin
                ADD <= adj_result;
                ACR <= adj_acr;
                AVR <= s1_q.avr;
                HC  <= s1_q.hc;
            end
        end
    end

    assign BUSY    = s1_q.valid;
    assign SB_OUT  = ADD_SB_EN  ? ADD : RST_VAL;
    assign ADL_OUT = ADD_ADL_EN ? ADD : RST_VAL;

endmodule

// File: tb/tb_alu_add_hold.sv
// Bench for alu_add_hold: directed scenarios plus a randomized stream against a plain-arithmetic model.
module tb_alu_add_hold;

    localparam int SUMS = 0;
    localparam int ANDS = 1;
    localparam int SRS  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go = 1'b0;
    logic [7:0] ai = 8'h00;
    logic [7:0] bi = 8'h00;
    logic       ci = 1'b0;
    logic [2:0] op = 3'd0;
    logic       daa = 1'b0;
    logic       dsa = 1'b0;
    logic       sb_en = 1'b0;
    logic       adl_en = 1'b0;
    logic [7:0] sb_out, adl_out, add;
    logic       acr, avr, hc, valid, busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [10:0] exp_q[$];

    alu_add_hold dut (
        .CLK(clk), .RST(rst), .GO(go), .AI(ai), .BI(bi), .CI(ci), .OP(op),
        .DAA(daa), .DSA(dsa), .ADD_SB_EN(sb_en), .ADD_ADL_EN(adl_en),
        .SB_OUT(sb_out), .ADL_OUT(adl_out), .ADD(add), .ACR(acr), .AVR(avr),
        .HC(hc), .VALID(valid), .BUSY(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: {result, carry, overflow, half carry} from plain integer arithmetic.
    function automatic logic [10:0] model(int o, int a, int b, int c, int d_a, int d_s);
        int raw, res, carry, half, ovf, lo, hi;
        carry = 0; half = 0; ovf = 0; res = 0;
        case (o)
            0: begin
                raw   = a + b + c;
                carry = (raw > 255) ? 1 : 0;
                raw   = raw % 256;
                half  = ((a % 16) + (b % 16) + c > 15) ? 1 : 0;
                ovf   = (((a >= 128) == (b >= 128)) && ((raw >= 128) != (a >= 128))) ? 1 : 0;
                res   = raw;
                if (d_a != 0) begin
                    if (half != 0 || raw % 16 > 9) res = res + 6;
                    if (carry != 0 || raw > 153) begin
                        res   = res + 96;
                        carry = 1;
                    end
                    res = res % 256;
                end else if (d_s != 0) begin
                    lo = raw % 16;
                    hi = raw / 16;
                    if (half == 0) lo = (lo + 10) % 16;
                    if (carry == 0) hi = (hi + 10) % 16;
                    res = hi * 16 + lo;
                end
            end
            1: res = a & b;
            2: res = a ^ b;
            4: begin
                res   = c * 128 + a / 2;
                carry = a % 2;
            end
            default: res = a | b;
        endcase
        return {8'(res), 1'(carry), 1'(ovf), 1'(half)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_go(input int o, input int a, input int b, input int c,
                            input int d_a, input int d_s);
        op  = 3'(o);
        ai  = 8'(a);
        bi  = 8'(b);
        ci  = 1'(c);
        daa = 1'(d_a);
        dsa = 1'(d_s);
        go  = 1'b1;
    endtask

    task automatic drive_idle();
        go  = 1'b0;
        ai  = 8'($urandom);
        bi  = 8'($urandom);
        ci  = 1'($urandom);
        op  = 3'($urandom);
        daa = 1'($urandom);
        dsa = 1'($urandom);
    endtask

    // Issues one operation and waits (bounded) for its VALID pulse.
    task automatic run_op(input int o, input int a, input int b, input int c,
                          input int d_a, input int d_s, output logic got);
        drive_go(o, a, b, c, d_a, d_s);
        step();
        drive_idle();
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            step();
            if (valid) got = 1'b1;
        end
    endtask

    task automatic test_reset_values();
        sb_en = 1'b1; adl_en = 1'b1;
        #1;
        n_checks++;
        if ({add, acr, avr, hc, valid, busy} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_state: got add=%h acr=%b avr=%b hc=%b valid=%b busy=%b, want all 0",
                     add, acr, avr, hc, valid, busy);
        end
        n_checks++;
        if ({sb_out, adl_out} !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_bus: got sb=%h adl=%h, want 00 00", sb_out, adl_out);
        end
        sb_en = 1'b0; adl_en = 1'b0;
    endtask

    task automatic test_overflow();
        drive_go(SUMS, 8'h50, 8'h50, 0, 0, 0);
        step();
        n_checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_stage1: got busy=%b valid=%b, want 1 0", busy, valid);
        end
        drive_idle();
        step();
        n_checks++;
        if ({valid, add, avr, acr, hc} !== {1'b1, 8'hA0, 1'b1, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL ovf_result: got valid=%b add=%h avr=%b acr=%b hc=%b, want 1 a0 1 0 0",
                     valid, add, avr, acr, hc);
        end
        step();
        n_checks++;
        if (valid !== 1'b0 || add !== 8'hA0) begin
            n_errors++;
            $display("FAIL ovf_hold: got valid=%b add=%h, want 0 a0", valid, add);
        end
    endtask

    task automatic test_decimal();
        logic got;
        run_op(SUMS, 8'h45, 8'h38, 0, 1, 0, got);
        n_checks++;
        if ({got, add, acr} !== {1'b1, 8'h83, 1'b0}) begin
            n_errors++;
            $display("FAIL daa_45_38: got valid=%b add=%h acr=%b, want 1 83 0", got, add, acr);
        end
        run_op(SUMS, 8'h99, 8'h01, 0, 1, 0, got);
        n_checks++;
        if ({got, add, acr} !== {1'b1, 8'h00, 1'b1}) begin
            n_errors++;
            $display("FAIL daa_99_01: got valid=%b add=%h acr=%b, want 1 00 1", got, add, acr);
        end
        run_op(SUMS, 8'h42, 8'hEC, 1, 0, 1, got);
        n_checks++;
        if ({got, add, acr} !== {1'b1, 8'h29, 1'b1}) begin
            n_errors++;
            $display("FAIL dsa_42_13: got valid=%b add=%h acr=%b, want 1 29 1", got, add, acr);
        end
        run_op(SUMS, 8'h45, 8'h38, 0, 1, 1, got);
        n_checks++;
        if ({got, add, acr} !== {1'b1, 8'h83, 1'b0}) begin
            n_errors++;
            $display("FAIL daa_dsa_both: got valid=%b add=%h acr=%b, want 1 83 0", got, add, acr);
        end
        run_op(ANDS, 8'hF9, 8'h9F, 0, 1, 1, got);
        n_checks++;
        if ({got, add, acr} !== {1'b1, 8'h99, 1'b0}) begin
            n_errors++;
            $display("FAIL dec_non_sums: got valid=%b add=%h acr=%b, want 1 99 0", got, add, acr);
        end
    endtask

    task automatic test_back_to_back();
        drive_go(SRS, 8'h81, 8'h5A, 1, 0, 0);
        step();
        drive_go(ANDS, 8'hF0, 8'h3C, 0, 0, 0);
        step();
        drive_idle();
        n_checks++;
        if ({valid, add, acr} !== {1'b1, 8'hC0, 1'b1}) begin
            n_errors++;
            $display("FAIL b2b_srs: got valid=%b add=%h acr=%b, want 1 c0 1", valid, add, acr);
        end
        step();
        n_checks++;
        if ({valid, add, acr} !== {1'b1, 8'h30, 1'b0}) begin
            n_errors++;
            $display("FAIL b2b_ands: got valid=%b add=%h acr=%b, want 1 30 0", valid, add, acr);
        end
        sb_en = 1'b1; adl_en = 1'b0;
        #1;
        n_checks++;
        if ({sb_out, adl_out} !== {8'h30, 8'h00}) begin
            n_errors++;
            $display("FAIL bus_sb_only: got sb=%h adl=%h, want 30 00", sb_out, adl_out);
        end
        sb_en = 1'b0; adl_en = 1'b1;
        #1;
        n_checks++;
        if ({sb_out, adl_out} !== {8'h00, 8'h30}) begin
            n_errors++;
            $display("FAIL bus_adl_only: got sb=%h adl=%h, want 00 30", sb_out, adl_out);
        end
        sb_en = 1'b1;
        #1;
        n_checks++;
        if ({sb_out, adl_out} !== {8'h30, 8'h30}) begin
            n_errors++;
            $display("FAIL bus_both: got sb=%h adl=%h, want 30 30", sb_out, adl_out);
        end
        sb_en = 1'b0; adl_en = 1'b0;
        step();
        n_checks++;
        if (valid !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_pulse: got valid=%b, want 0", valid);
        end
    endtask

    task automatic test_random();
        logic [10:0] e;
        logic        prev_go;
        prev_go = 1'b0;
        for (int cyc = 0; cyc < 403; cyc++) begin
            if (valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL rnd_extra_valid: got valid=1 at cycle %0d, want no pending op", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({add, acr, avr, hc} !== e) begin
                        n_errors++;
                        $display("FAIL rnd_result: got add=%h acr=%b avr=%b hc=%b, want add=%h acr=%b avr=%b hc=%b",
                                 add, acr, avr, hc, e[10:3], e[2], e[1], e[0]);
                    end
                end
            end
            n_checks++;
            if (busy !== prev_go) begin
                n_errors++;
                $display("FAIL rnd_busy: got busy=%b, want %b at cycle %0d", busy, prev_go, cyc);
            end
            if (cyc < 400 && $urandom_range(0, 3) != 0) begin
                drive_go(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                         int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                         int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
                exp_q.push_back(model(int'(op), int'(ai), int'(bi), int'(ci), int'(daa), int'(dsa)));
                prev_go = 1'b1;
            end else begin
                drive_idle();
                prev_go = 1'b0;
            end
            step();
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL rnd_drain: got %0d ops without VALID, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        logic got;
        logic saw;
        run_op(SUMS, 8'h50, 8'h50, 0, 0, 0, got);
        drive_go(SUMS, 8'h01, 8'h01, 0, 0, 0);
        step();
        drive_idle();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({add, acr, avr, hc, valid, busy} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_mid_state: got add=%h acr=%b avr=%b hc=%b valid=%b busy=%b, want all 0",
                     add, acr, avr, hc, valid, busy);
        end
        step();
        step();
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (valid) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0 || add !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_mid_drop: got valid_seen=%b add=%h, want 0 00", saw, add);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset_values();
        rst = 1'b0;
        step();
        test_overflow();
        test_decimal();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
